// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    // Cache-wait FSM state
    typedef enum logic {
        RUN,
        WAIT
    } pipe_state_e;

    // Per-register freeze/flush controls driven into the pipeline registers
    typedef struct packed {
        logic freeze_pc;
        logic freeze_if;
        logic freeze_id;
        logic freeze_exe;
        logic freeze_mem;
        logic flush_if;
        logic flush_id;
    } pipe_ctrl_t;

    localparam int unsigned WAIT_CNT_W = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_cnt;

    // Clear wins over increment; increment stops at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: priority decode of memory stall, taken
// branch and RAW hazard into freeze/flush pins, plus cache-wait FSM,
// timeout detection and saturating performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_ID,
    input  logic             branch_taken_EXE,
    input  logic             mem_req_MEM,
    input  logic             mem_ready,
    input  logic             err_clr,
    output logic             freeze_PC,
    output logic             freeze_IF,
    output logic             freeze_ID,
    output logic             freeze_EXE,
    output logic             freeze_MEM,
    output logic             flush_IF,
    output logic             flush_ID,
    output logic             mem_wait,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

    logic                  w_mem_stall;
    logic                  w_any_freeze;
    pipe_ctrl_t            w_ctrl;
    logic [WAIT_CNT_W-1:0] w_wait_cnt;
    logic                  w_wait_inc;
    logic                  w_wait_clr;

    pipe_state_e           r_state;
    logic                  r_mem_wait;
    logic                  r_timeout_err;

    assign w_mem_stall = mem_req_MEM & ~mem_ready;

    // Priority decode: memory stall > taken branch > ID hazard
    always_comb begin
        w_ctrl = '0;
        if (w_mem_stall) begin
            w_ctrl.freeze_pc  = 1'b1;
            w_ctrl.freeze_if  = 1'b1;
            w_ctrl.freeze_id  = 1'b1;
            w_ctrl.freeze_exe = 1'b1;
            w_ctrl.freeze_mem = 1'b1;
        end else if (branch_taken_EXE) begin
            w_ctrl.flush_if = 1'b1;
            w_ctrl.flush_id = 1'b1;
        end else if (hazard_ID) begin
            w_ctrl.freeze_pc = 1'b1;
            w_ctrl.freeze_if = 1'b1;
            w_ctrl.flush_id  = 1'b1;
        end
    end

    // Cache-wait FSM with registered mem_wait output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_mem_wait <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= WAIT;
                        r_mem_wait <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_ready || !mem_req_MEM) begin
                        r_state    <= RUN;
                        r_mem_wait <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_mem_wait <= 1'b0;
                end
            endcase
        end
    end

    // Sticky timeout flag; a coincident set beats err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
        end else if ((r_state == WAIT) && w_mem_stall && (w_wait_cnt == TIMEOUT_VAL)) begin
            r_timeout_err <= 1'b1;
        end else if (err_clr) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign w_wait_inc   = (r_state == WAIT);
    assign w_wait_clr   = (r_state == RUN);
    assign w_any_freeze = w_ctrl.freeze_pc | w_ctrl.freeze_if | w_ctrl.freeze_id |
                          w_ctrl.freeze_exe | w_ctrl.freeze_mem;

    sat_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_wait_inc),
        .i_clr (w_wait_clr),
        .o_cnt (w_wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_any_freeze),
        .i_clr (1'b0),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_ctrl.flush_if),
        .i_clr (1'b0),
        .o_cnt (flush_cnt)
    );

    assign freeze_PC       = w_ctrl.freeze_pc;
    assign freeze_IF       = w_ctrl.freeze_if;
    assign freeze_ID       = w_ctrl.freeze_id;
    assign freeze_EXE      = w_ctrl.freeze_exe;
    assign freeze_MEM      = w_ctrl.freeze_mem;
    assign flush_IF        = w_ctrl.flush_if;
    assign flush_ID        = w_ctrl.flush_id;
    assign mem_wait        = r_mem_wait;
    assign mem_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

    localparam int unsigned TB_TO  = 4;
    localparam int unsigned TB_CW  = 4;
    localparam int unsigned CMAX   = 15;

    typedef struct {
        logic [6:0] ctrl;   // {fPC,fIF,fID,fEXE,fMEM,flIF,flID}
        logic       mwait;
        logic       err;
        int unsigned scnt;
        int unsigned fcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hazard_ID = 1'b0, branch_taken_EXE = 1'b0, mem_req_MEM = 1'b0;
    logic mem_ready = 1'b0, err_clr = 1'b0;
    logic freeze_PC, freeze_IF, freeze_ID, freeze_EXE, freeze_MEM;
    logic flush_IF, flush_ID, mem_wait, mem_timeout_err;
    logic [TB_CW-1:0] stall_cnt, flush_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    exp_t sb[$];

    // reference model state
    logic        m_wait = 1'b0;
    logic        m_err  = 1'b0;
    int unsigned m_wcnt = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TB_TO), .CNT_W(TB_CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hazard_ID        (hazard_ID),
        .branch_taken_EXE (branch_taken_EXE),
        .mem_req_MEM      (mem_req_MEM),
        .mem_ready        (mem_ready),
        .err_clr          (err_clr),
        .freeze_PC        (freeze_PC),
        .freeze_IF        (freeze_IF),
        .freeze_ID        (freeze_ID),
        .freeze_EXE       (freeze_EXE),
        .freeze_MEM       (freeze_MEM),
        .flush_IF         (flush_IF),
        .flush_ID         (flush_ID),
        .mem_wait         (mem_wait),
        .mem_timeout_err  (mem_timeout_err),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_ctrl(input logic h, b, req, rdy);
        if (req && !rdy)  return 7'b11111_00;
        else if (b)       return 7'b00000_11;
        else if (h)       return 7'b11000_01;
        else              return 7'b00000_00;
    endfunction

    task automatic model_reset();
        m_wait = 1'b0; m_err = 1'b0; m_wcnt = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_edge(input logic h, b, req, rdy, clr);
        logic       stall;
        logic [6:0] c;
        stall = req && !rdy;
        c = exp_ctrl(h, b, req, rdy);
        if (m_wait && stall && (m_wcnt == TB_TO)) m_err = 1'b1;
        else if (clr)                              m_err = 1'b0;
        if ((|c[6:2]) && (m_stall != CMAX)) m_stall++;
        if (c[1] && (m_flush != CMAX))      m_flush++;
        if (!m_wait)               m_wcnt = 0;
        else if (m_wcnt != 65535)  m_wcnt++;
        m_wait = stall;
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance model at posedge
    task automatic step(input logic h, b, req, rdy, clr);
        exp_t e, got;
        hazard_ID = h; branch_taken_EXE = b; mem_req_MEM = req;
        mem_ready = rdy; err_clr = clr;
        e.ctrl  = exp_ctrl(h, b, req, rdy);
        e.mwait = m_wait;
        e.err   = m_err;
        e.scnt  = m_stall;
        e.fcnt  = m_flush;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        n_tests++;
        if ({freeze_PC, freeze_IF, freeze_ID, freeze_EXE, freeze_MEM, flush_IF, flush_ID} !== got.ctrl) begin
            n_fail++;
            $display("FAIL ctrl t=%0t got=%b exp=%b", $time,
                     {freeze_PC, freeze_IF, freeze_ID, freeze_EXE, freeze_MEM, flush_IF, flush_ID}, got.ctrl);
        end
        n_tests++;
        if ({mem_wait, mem_timeout_err} !== {got.mwait, got.err}) begin
            n_fail++;
            $display("FAIL status t=%0t got wait/err=%b%b exp=%b%b", $time,
                     mem_wait, mem_timeout_err, got.mwait, got.err);
        end
        n_tests++;
        if ((stall_cnt !== TB_CW'(got.scnt)) || (flush_cnt !== TB_CW'(got.fcnt))) begin
            n_fail++;
            $display("FAIL counters t=%0t got stall=%0d flush=%0d exp stall=%0d flush=%0d", $time,
                     stall_cnt, flush_cnt, got.scnt, got.fcnt);
        end
        @(posedge clk);
        model_edge(h, b, req, rdy, clr);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset mid-cycle, check registered outputs cleared, release after an edge
    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        n_tests++;
        if ({mem_wait, mem_timeout_err} !== 2'b00 || stall_cnt !== '0 || flush_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_regs got wait=%b err=%b stall=%0d flush=%0d exp all 0",
                     mem_wait, mem_timeout_err, stall_cnt, flush_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        apply_reset();
        idle();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (mem_wait !== 1'b1 || stall_cnt !== TB_CW'(5)) begin
            n_fail++;
            $display("FAIL mid_wait got wait=%b stall=%0d exp wait=1 stall=5", mem_wait, stall_cnt);
        end
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (mem_wait !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0 || freeze_PC !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_wait_reset got wait=%b stall=%0d flush=%0d fPC=%b exp 0 0 0 1",
                     mem_wait, stall_cnt, flush_cnt, freeze_PC);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_branch_beats_hazard();
        apply_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        n_tests++;
        if (flush_cnt !== TB_CW'(1) || stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL branch_cnt got flush=%0d stall=%0d exp 1 0", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_hazard_alone();
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        n_tests++;
        if (stall_cnt !== TB_CW'(2) || flush_cnt !== '0) begin
            n_fail++;
            $display("FAIL hazard_cnt got stall=%0d flush=%0d exp 2 0", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_stall_pending_branch();
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle();
        n_tests++;
        if (stall_cnt !== TB_CW'(3) || flush_cnt !== TB_CW'(1)) begin
            n_fail++;
            $display("FAIL pend_branch got stall=%0d flush=%0d exp 3 1", stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        // one RUN cycle, then WAIT; flag must rise after the 5th WAIT edge
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (mem_timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_early i=%0d got=%b exp=0", i, mem_timeout_err);
            end
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (mem_timeout_err !== 1'b1 || freeze_MEM !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_set got err=%b fMEM=%b exp 1 1", mem_timeout_err, freeze_MEM);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        n_tests++;
        if (mem_timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clr got=%b exp=0", mem_timeout_err);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        n_tests++;
        if (stall_cnt !== TB_CW'(15)) begin
            n_fail++;
            $display("FAIL sat got=%0d exp=15", stall_cnt);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (stall_cnt !== TB_CW'(15)) begin
            n_fail++;
            $display("FAIL sat_hold got=%0d exp=15", stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 7) == 0));
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_reset_mid_wait();
        test_branch_beats_hazard();
        test_hazard_alone();
        test_stall_pending_branch();
        test_timeout();
        test_saturation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
